// File: rtl/fetch_queue_unit.sv
// Fetch unit: generates the fetch PC, issues pipelined imem requests and buffers
// returned {pc,instr} pairs in a DEPTH-entry queue drained by decode.
module fetch_queue_unit #(
    parameter int unsigned     AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = AW'(32'h0000_3000),
    parameter logic [AW-1:0]   EXC_PC   = AW'(32'h0000_4180),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          int_req,
    input  logic          eret,
    input  logic [AW-1:0] eret_addr,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_pc,
    output logic [31:0]   out_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] fpc;

    logic [AW-1:0] q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] q_head, q_tail;
    logic [CW-1:0] q_count;

    logic [AW-1:0]    t_pc [DEPTH];
    logic [DEPTH-1:0] t_live;
    logic [PW-1:0]    t_head, t_tail;
    logic [CW-1:0]    outstanding;

    logic          redirect;
    logic [AW-1:0] target;
    logic [CW:0]   in_use;
    logic          credit;
    logic          issue;
    logic          resp_keep;
    logic          pop;

    assign redirect = int_req | eret | jump;

    always_comb begin
        target = jump_addr;
        if (eret)
            target = eret_addr;
        if (int_req)
            target = EXC_PC;
        target[1:0] = 2'b00;
    end

    // Credits cover both queued words and in-flight fetches, so neither store can overflow.
    assign in_use    = {1'b0, outstanding} + {1'b0, q_count};
    assign credit    = in_use < (CW+1)'(DEPTH);
    assign imem_req  = reset && !redirect && credit;
    assign imem_addr = fpc;
    assign issue     = imem_req && imem_gnt;
    assign resp_keep = imem_rvalid && t_live[t_head] && !redirect;

    assign out_valid = (q_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_pc    = out_valid ? q_pc[q_head]    : '0;
    assign out_instr = out_valid ? q_instr[q_head] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc         <= RESET_PC;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            t_head      <= '0;
            t_tail      <= '0;
            t_live      <= '0;
            outstanding <= '0;
        end else begin
            if (redirect)
                fpc <= target;
            else if (issue)
                fpc <= fpc + AW'(4);

            if (issue)
                t_tail <= t_tail + 1'b1;
            if (imem_rvalid)
                t_head <= t_head + 1'b1;
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);

            // Late responses still retire through the tracker; only their live bit is dropped.
            if (redirect)
                t_live <= '0;
            else if (issue)
                t_live[t_tail] <= 1'b1;

            if (redirect) begin
                q_head  <= '0;
                q_tail  <= '0;
                q_count <= '0;
            end else begin
                if (resp_keep)
                    q_tail <= q_tail + 1'b1;
                if (pop)
                    q_head <= q_head + 1'b1;
                q_count <= q_count + CW'(resp_keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            t_pc[t_tail] <= fpc;
        if (resp_keep) begin
            q_pc[q_tail]    <= t_pc[t_head];
            q_instr[q_tail] <= imem_rdata;
        end
    end

    a_rvalid_tracked: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a simple in-order imem responder model.
module tb_fetch_queue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        int_req, eret, jump;
    logic [31:0] eret_addr, jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    logic        mem_hold = 1'b0;
    int unsigned grant_cnt = 0;
    logic [31:0] last_grant = '0;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .AW      (32),
        .RESET_PC(32'h0000_3000),
        .EXC_PC  (32'h0000_4180),
        .DEPTH   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .int_req    (int_req),
        .eret       (eret),
        .eret_addr  (eret_addr),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_instr  (out_instr)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: present a due response, record any grant, advance past the edge.
    task automatic cycle();
        logic [31:0] a;
        if (!mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            a = mq_addr.pop_front();
            void'(mq_due.pop_front());
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        if (imem_req && imem_gnt) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + mem_lat);
            grant_cnt++;
            last_grant = imem_addr;
        end
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        int_req  = 1'b0;
        eret     = 1'b0;
        jump     = 1'b0;
        mem_hold = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        imem_rvalid = 1'b0;
        cycle();
        cycle();
        grant_cnt = 0;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0; int_req = 1'b0; eret = 1'b0; jump = 1'b0;
        eret_addr = '0; jump_addr = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;

        // reset state
        cycle();
        check("rst_req",   {31'b0, imem_req},  32'd0);
        check("rst_addr",  imem_addr,          32'h0000_3000);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_pc",    out_pc,             32'd0);
        check("rst_instr", out_instr,          32'd0);

        // 1: streaming with out_ready=1
        do_reset();
        check("t1_req",  {31'b0, imem_req}, 32'd1);
        check("t1_addr", imem_addr,         32'h0000_3000);
        cycle();
        check("t1_v0", {31'b0, out_valid}, 32'd0);
        cycle();
        check("t1_v1",  {31'b0, out_valid}, 32'd1);
        check("t1_pc0", out_pc,             32'h0000_3000);
        check("t1_in0", out_instr,          instr_of(32'h0000_3000));
        cycle();
        check("t1_pc1", out_pc, 32'h0000_3004);
        cycle();
        check("t1_pc2", out_pc, 32'h0000_3008);

        // 2: out_ready=0 fills the queue and stops issue
        out_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        check("t2_grants", grant_cnt,           32'd4);
        check("t2_lastg",  last_grant,          32'h0000_300C);
        check("t2_req",    {31'b0, imem_req},   32'd0);
        check("t2_valid",  {31'b0, out_valid},  32'd1);
        check("t2_head",   out_pc,              32'h0000_3000);
        out_ready = 1'b1;
        cycle();
        check("t2_req2",  {31'b0, imem_req}, 32'd1);
        check("t2_addr2", imem_addr,         32'h0000_3010);
        check("t2_head2", out_pc,            32'h0000_3004);

        // 3: jump with a queued word and two fetches in flight
        out_ready = 1'b0;
        do_reset();
        cycle();
        cycle();
        mem_hold = 1'b1;
        cycle();
        check("t3_pre_v", {31'b0, out_valid}, 32'd1);
        jump = 1'b1; jump_addr = 32'h0000_5003;
        #1;
        check("t3_jreq", {31'b0, imem_req}, 32'd0);
        cycle();
        jump = 1'b0;
        mem_hold = 1'b0;
        out_ready = 1'b1;
        check("t3_flush", {31'b0, out_valid}, 32'd0);
        check("t3_addr",  imem_addr,          32'h0000_5000);
        begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 12 && !found; i++) begin
                cycle();
                if (out_valid) begin
                    found = 1'b1;
                    check("t3_pc",    out_pc,    32'h0000_5000);
                    check("t3_instr", out_instr, instr_of(32'h0000_5000));
                end
            end
            check("t3_found", {31'b0, found}, 32'd1);
        end

        // 4: redirect priority and back-to-back redirects
        do_reset();
        int_req = 1'b1; eret = 1'b1; eret_addr = 32'h0000_3100;
        jump = 1'b1; jump_addr = 32'h0000_5000;
        cycle();
        int_req = 1'b0; eret = 1'b0; jump = 1'b0;
        check("t4_int", imem_addr, 32'h0000_4180);
        eret = 1'b1; jump = 1'b1;
        cycle();
        eret = 1'b0; jump = 1'b0;
        check("t4_eret", imem_addr, 32'h0000_3100);
        jump = 1'b1; jump_addr = 32'h0000_6000;
        cycle();
        jump_addr = 32'h0000_7000;
        cycle();
        jump = 1'b0;
        check("t4_b2b", imem_addr, 32'h0000_7000);

        // 5: PC wrap
        jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        cycle();
        jump = 1'b0;
        check("t5_top", imem_addr, 32'hFFFF_FFFC);
        cycle();
        check("t5_wrap", imem_addr, 32'h0000_0000);

        // 6: reset mid-stream with three queued words
        out_ready = 1'b0;
        do_reset();
        repeat (4) cycle();
        check("t6_pre_v",  {31'b0, out_valid}, 32'd1);
        check("t6_pre_pc", out_pc,             32'h0000_3000);
        reset = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        #1;
        check("t6_v",   {31'b0, out_valid}, 32'd0);
        check("t6_req", {31'b0, imem_req},  32'd0);
        check("t6_pc",  out_pc,             32'd0);
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        check("t6_addr", imem_addr,         32'h0000_3000);
        check("t6_req2", {31'b0, imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
